// File: rtl/con_bus_port.sv
// con_bus_port
// DUT-side endpoint of the three-lane bidirectional accelerator bus.
//
// Receive direction: host words arriving on con_1..con_3 with the
// con_valid/con_ready handshake are pushed into a small FIFO. The FIFO
// hands them to the compute core on in_valid/in_ready/in_data.
// Transmit direction: when the core raises res_valid, the bus is turned
// around (one dead cycle). Results are then streamed onto the lanes with
// output_valid and the output_x/y/ch coordinates. Finally the bus is
// handed back to the host (another dead cycle).
//
// Ports:
//   clk, arst_n             clock, asynchronous active-low reset
//   con_1..con_3            shared bidirectional lanes
//   con_valid / con_ready   host word handshake
//   dut_driving_cons        block owns the lanes; the host must release them
//   last_load_K             one-cycle pulse after the K_WORDS-th accept since start
//   output_valid, output_*  result word valid on the lanes, plus its coordinates
//   start                   clears the kernel transfer counter
//   in_valid/in_ready/in_data          FIFO to core, {con_3,con_2,con_1}
//   res_valid/res_ready/res_data/res_* core results to transmit
module con_bus_port #(
    parameter int DATA_WIDTH         = 16,
    parameter int FIFO_DEPTH         = 4,
    parameter int K_WORDS            = 9,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
    inout  wire  [DATA_WIDTH-1:0]                 con_1,
    inout  wire  [DATA_WIDTH-1:0]                 con_2,
    inout  wire  [DATA_WIDTH-1:0]                 con_3,
    input  logic                                  con_valid,
    output logic                                  con_ready,
    output logic                                  dut_driving_cons,
    output logic                                  last_load_K,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    input  logic                                  start,
    output logic                                  in_valid,
    input  logic                                  in_ready,
    output logic [3*DATA_WIDTH-1:0]               in_data,
    input  logic                                  res_valid,
    output logic                                  res_ready,
    input  logic [3*DATA_WIDTH-1:0]               res_data,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  res_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] res_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] res_ch
);

    localparam int WORD_W = 3 * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int KC_W   = $clog2(K_WORDS + 1);
    localparam int XW     = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW     = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW     = $clog2(OUTPUT_NB_CHANNELS);

    typedef enum logic [2:0] {
        ST_RX      = 3'd0,
        ST_TURN_TX = 3'd1,
        ST_TX      = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_TURN_RX = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                drive_cons_r;
    logic                lanes_en_r;
    logic                res_ready_r;

    logic [WORD_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                con_ready_s;
    logic                accept_s;
    logic                pop_s;

    logic [KC_W-1:0]     kcnt_r;
    logic [KC_W-1:0]     kbase_s;
    logic [KC_W-1:0]     kcnt_nxt_s;
    logic                llk_nxt_s;
    logic                last_load_r;

    logic [WORD_W-1:0]   out_q_r;
    logic [XW-1:0]       out_x_r;
    logic [YW-1:0]       out_y_r;
    logic [CW-1:0]       out_ch_r;
    logic                output_valid_r;
    logic                capture_s;

    // FIFO status and handshake decode
    always_comb begin
        fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        // Gated by arst_n so the handshake is idle while reset is held, yet
        // ready in the very first cycle after release. A pending result
        // blocks acceptance because the output direction has priority.
        con_ready_s  = arst_n && (state_r == ST_RX) && !fifo_full_s && !res_valid;
        accept_s     = con_valid && con_ready_s;
        pop_s        = !fifo_empty_s && in_ready;
        capture_s    = res_ready_r && res_valid;
    end

    // Bus direction next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RX: begin
                if (res_valid) begin
                    state_nxt_s = ST_TURN_TX;
                end else begin
                    state_nxt_s = ST_RX;
                end
            end
            ST_TURN_TX: state_nxt_s = ST_TX;
            ST_TX: begin
                if (res_valid) begin
                    state_nxt_s = ST_TX;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DRAIN:   state_nxt_s = ST_TURN_RX;
            ST_TURN_RX: state_nxt_s = ST_RX;
            default:    state_nxt_s = ST_RX;
        endcase
    end

    // State register with direction flags decoded from the next state
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r      <= ST_RX;
            drive_cons_r <= 1'b0;
            lanes_en_r   <= 1'b0;
            res_ready_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            drive_cons_r <= (state_nxt_s == ST_TURN_TX) || (state_nxt_s == ST_TX) ||
                            (state_nxt_s == ST_DRAIN);
            lanes_en_r   <= (state_nxt_s == ST_TX) || (state_nxt_s == ST_DRAIN);
            res_ready_r  <= (state_nxt_s == ST_TX);
        end
    end

    // Receive FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {WORD_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                fifo_mem_r[wr_ptr_r] <= {con_3, con_2, con_1};
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Kernel transfer counter; start takes effect before a coincident accept
    always_comb begin
        if (start) begin
            kbase_s = {KC_W{1'b0}};
        end else begin
            kbase_s = kcnt_r;
        end
        llk_nxt_s = accept_s && (kbase_s == KC_W'(K_WORDS - 1));
        if (accept_s && (kbase_s < KC_W'(K_WORDS))) begin
            kcnt_nxt_s = kbase_s + KC_W'(1);
        end else begin
            kcnt_nxt_s = kbase_s;
        end
    end

    // Kernel counter and last-load pulse registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            kcnt_r      <= {KC_W{1'b0}};
            last_load_r <= 1'b0;
        end else begin
            kcnt_r      <= kcnt_nxt_s;
            last_load_r <= llk_nxt_s;
        end
    end

    // Transmit holding register and coordinates, loaded once per result beat
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_q_r        <= {WORD_W{1'b0}};
            out_x_r        <= {XW{1'b0}};
            out_y_r        <= {YW{1'b0}};
            out_ch_r       <= {CW{1'b0}};
            output_valid_r <= 1'b0;
        end else begin
            output_valid_r <= capture_s;
            if (capture_s) begin
                out_q_r  <= res_data;
                out_x_r  <= res_x;
                out_y_r  <= res_y;
                out_ch_r <= res_ch;
            end
        end
    end

    // Lanes are driven only in TX and DRAIN; the flag clears asynchronously on reset
    assign con_1 = lanes_en_r ? out_q_r[DATA_WIDTH-1:0]              : {DATA_WIDTH{1'bz}};
    assign con_2 = lanes_en_r ? out_q_r[2*DATA_WIDTH-1:DATA_WIDTH]   : {DATA_WIDTH{1'bz}};
    assign con_3 = lanes_en_r ? out_q_r[3*DATA_WIDTH-1:2*DATA_WIDTH] : {DATA_WIDTH{1'bz}};

    assign con_ready        = con_ready_s;
    assign dut_driving_cons = drive_cons_r;
    assign res_ready        = res_ready_r;
    assign last_load_K      = last_load_r;
    assign output_valid     = output_valid_r;
    assign output_x         = out_x_r;
    assign output_y         = out_y_r;
    assign output_ch        = out_ch_r;
    assign in_valid         = !fifo_empty_s;
    assign in_data          = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_con_bus_port.sv
// Self-checking bench for con_bus_port: the host side of the lanes is
// modelled with its own tri-state drivers; receive and transmit words are
// tracked in scoreboard queues.
module tb_con_bus_port;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        con_valid, start, in_ready, res_valid, host_en;
    logic [15:0] hd1, hd2, hd3;
    logic [47:0] res_data;
    logic [6:0]  res_x, res_y;
    logic [5:0]  res_ch;
    wire  [15:0] con_1, con_2, con_3;
    logic        con_ready, dut_driving_cons, last_load_K, output_valid;
    logic [6:0]  output_x, output_y;
    logic [5:0]  output_ch;
    logic        in_valid, res_ready;
    logic [47:0] in_data;

    logic [47:0] rx_q [$];
    logic [67:0] tx_q [$];
    int          checks = 0;
    int          failures = 0;

    // The host releases the lanes whenever the DUT claims them
    wire host_oe = host_en && !dut_driving_cons;
    assign con_1 = host_oe ? hd1 : 16'bz;
    assign con_2 = host_oe ? hd2 : 16'bz;
    assign con_3 = host_oe ? hd3 : 16'bz;

    con_bus_port dut (
        .clk(clk), .arst_n(arst_n),
        .con_1(con_1), .con_2(con_2), .con_3(con_3),
        .con_valid(con_valid), .con_ready(con_ready),
        .dut_driving_cons(dut_driving_cons), .last_load_K(last_load_K),
        .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
        .output_ch(output_ch), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_x(res_x), .res_y(res_y), .res_ch(res_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        arst_n = 1'b0; con_valid = 1'b0; start = 1'b0; in_ready = 1'b0; res_valid = 1'b0;
        host_en = 1'b1; hd1 = 16'h0; hd2 = 16'h0; hd3 = 16'h0;
        res_data = 48'h0; res_x = 7'd0; res_y = 7'd0; res_ch = 6'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (con_ready !== 1'b0) begin failures++; $display("FAIL rst_con_ready got=%b exp=0", con_ready); end
        checks++; if (in_valid !== 1'b0) begin failures++; $display("FAIL rst_in_valid got=%b exp=0", in_valid); end
        checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL rst_res_ready got=%b exp=0", res_ready); end
        checks++; if (dut_driving_cons !== 1'b0) begin failures++; $display("FAIL rst_driving got=%b exp=0", dut_driving_cons); end
        checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL rst_output_valid got=%b exp=0", output_valid); end
        checks++; if (last_load_K !== 1'b0) begin failures++; $display("FAIL rst_last_load got=%b exp=0", last_load_K); end
        checks++; if ({output_x, output_y, output_ch} !== 20'h0) begin failures++; $display("FAIL rst_coords got=%h exp=0", {output_x, output_y, output_ch}); end
        checks++; if ({con_3, con_2, con_1} !== 48'h0) begin failures++; $display("FAIL rst_lanes got=%h exp=0", {con_3, con_2, con_1}); end
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        checks++; if (con_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", con_ready); end
    endtask

    task automatic test_rx_basic();
        logic [47:0] exp;
        in_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) begin
                con_valid = 1'b1; hd1 = 16'(i + 1); hd2 = 16'(i + 2); hd3 = 16'(i + 3);
            end else begin
                con_valid = 1'b0;
            end
            #1;
            if (i < 3) begin
                checks++; if (con_ready !== 1'b1) begin failures++; $display("FAIL rx_no_stall[%0d] got=%b exp=1", i, con_ready); end
            end
            if (i == 1) begin
                checks++; if (in_valid !== 1'b1 || in_data !== 48'h0003_0002_0001) begin failures++; $display("FAIL rx_latency got=%b/%h exp=1/000300020001", in_valid, in_data); end
            end
            if (in_valid && in_ready) begin
                checks++;
                if (rx_q.size() == 0) begin failures++; $display("FAIL rx_basic_extra got=%h exp=none", in_data); end
                else begin exp = rx_q.pop_front(); if (in_data !== exp) begin failures++; $display("FAIL rx_basic_data got=%h exp=%h", in_data, exp); end end
            end
            if (con_valid && con_ready) rx_q.push_back({hd3, hd2, hd1});
        end
        checks++; if (rx_q.size() != 0 || in_valid !== 1'b0) begin failures++; $display("FAIL rx_basic_empty got=%0d/%b exp=0/0", rx_q.size(), in_valid); end
    endtask

    task automatic test_fifo_full();
        logic [47:0] exp;
        int acc = 0;
        in_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            con_valid = 1'b1; hd1 = 16'(16'h0100 + i); hd2 = 16'(16'h0200 + i); hd3 = 16'(16'h0300 + i);
            #1;
            if (con_valid && con_ready) begin acc++; rx_q.push_back({hd3, hd2, hd1}); end
        end
        checks++; if (acc != 4) begin failures++; $display("FAIL full_accepts got=%0d exp=4", acc); end
        checks++; if (con_ready !== 1'b0) begin failures++; $display("FAIL full_con_ready got=%b exp=0", con_ready); end
        con_valid = 1'b0;
        in_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (in_valid) begin
                checks++;
                if (rx_q.size() == 0) begin failures++; $display("FAIL full_extra got=%h exp=none", in_data); end
                else begin exp = rx_q.pop_front(); if (in_data !== exp) begin failures++; $display("FAIL full_order got=%h exp=%h", in_data, exp); end end
            end
            @(negedge clk);
            #1;
            if (c == 0) begin
                checks++; if (con_ready !== 1'b1) begin failures++; $display("FAIL full_ready_return got=%b exp=1", con_ready); end
            end
        end
        checks++; if (rx_q.size() != 0 || in_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%0d/%b exp=0/0", rx_q.size(), in_valid); end
    endtask

    task automatic test_kernel();
        logic [47:0] exp;
        logic        exp_llk, acc;
        int          kc, kb, pulses;
        in_ready = 1'b1;
        kc = 0;
        for (int r = 0; r < 2; r++) begin
            exp_llk = 1'b0;
            pulses = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                checks++; if (last_load_K !== exp_llk) begin failures++; $display("FAIL kernel_pulse r%0d[%0d] got=%b exp=%b", r, i, last_load_K, exp_llk); end
                if (last_load_K === 1'b1) pulses++;
                start = (i == 0);
                con_valid = (r == 0) ? (i >= 1 && i <= 10) : (i <= 8);
                hd1 = 16'(16'h0400 + i); hd2 = 16'(16'h0500 + r); hd3 = 16'h0600;
                #1;
                if (in_valid && in_ready) begin
                    checks++;
                    if (rx_q.size() == 0) begin failures++; $display("FAIL kernel_extra got=%h exp=none", in_data); end
                    else begin exp = rx_q.pop_front(); if (in_data !== exp) begin failures++; $display("FAIL kernel_data got=%h exp=%h", in_data, exp); end end
                end
                acc = con_valid && con_ready;
                if (acc) rx_q.push_back({hd3, hd2, hd1});
                kb = start ? 0 : kc;
                exp_llk = acc && (kb == 8);
                kc = (acc && kb < 9) ? kb + 1 : kb;
            end
            checks++; if (pulses != 1) begin failures++; $display("FAIL kernel_pulse_count r%0d got=%0d exp=1", r, pulses); end
        end
        start = 1'b0;
        con_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (rx_q.size() != 0 || in_valid !== 1'b0) begin failures++; $display("FAIL kernel_drained got=%0d/%b exp=0/0", rx_q.size(), in_valid); end
    endtask

    task automatic test_back_to_back_tx();
        logic [67:0] exp;
        int b = 0;
        con_valid = 1'b0; in_ready = 1'b1;
        hd1 = 16'h0; hd2 = 16'h0; hd3 = 16'h0;
        @(negedge clk);
        res_valid = 1'b1; res_data = {16'hA000, 16'hB000, 16'hC000};
        res_x = 7'd5; res_y = 7'd7; res_ch = 6'd2;
        #1;
        checks++; if (res_ready !== 1'b0 || con_ready !== 1'b0) begin failures++; $display("FAIL tx_rx_state got=%b/%b exp=0/0", res_ready, con_ready); end
        @(negedge clk);
        checks++; if (dut_driving_cons !== 1'b1 || res_ready !== 1'b0 || output_valid !== 1'b0) begin failures++; $display("FAIL tx_turn got=%b/%b/%b exp=1/0/0", dut_driving_cons, res_ready, output_valid); end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++; if (output_valid !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL tx_valid_run[%0d] got=%b exp=%b", c, output_valid, (c >= 1 && c <= 3)); end
            if (output_valid) begin
                checks++;
                if (tx_q.size() == 0) begin failures++; $display("FAIL tx_extra got=%h exp=none", {con_3, con_2, con_1}); end
                else begin
                    exp = tx_q.pop_front();
                    if ({con_3, con_2, con_1, output_x, output_y, output_ch} !== exp) begin failures++; $display("FAIL tx_data got=%h exp=%h", {con_3, con_2, con_1, output_x, output_y, output_ch}, exp); end
                end
            end
            if (c == 4) begin
                checks++; if (dut_driving_cons !== 1'b1 || {con_3, con_2, con_1} !== 48'hA002_B002_C002) begin failures++; $display("FAIL tx_drain_hold got=%b/%h exp=1/a002b002c002", dut_driving_cons, {con_3, con_2, con_1}); end
            end
            if (c == 5) begin
                checks++; if (dut_driving_cons !== 1'b0 || con_ready !== 1'b0 || {con_3, con_2, con_1} !== 48'h0) begin failures++; $display("FAIL tx_turn_rx got=%b/%b/%h exp=0/0/0", dut_driving_cons, con_ready, {con_3, con_2, con_1}); end
            end
            if (c == 6) begin
                checks++; if (con_ready !== 1'b1) begin failures++; $display("FAIL tx_back_rx got=%b exp=1", con_ready); end
            end
            if (b < 3) begin
                res_valid = 1'b1;
                res_data = {16'(16'hA000 + b), 16'(16'hB000 + b), 16'(16'hC000 + b)};
                res_x = 7'(5 + b); res_y = 7'd7; res_ch = 6'd2;
            end else begin
                res_valid = 1'b0;
            end
            #1;
            if (c == 0) begin
                checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL tx_first_ready got=%b exp=1", res_ready); end
            end
            if (res_valid && res_ready) begin tx_q.push_back({res_data, res_x, res_y, res_ch}); b++; end
        end
        checks++; if (tx_q.size() != 0 || b != 3) begin failures++; $display("FAIL tx_complete got=%0d/%0d exp=0/3", tx_q.size(), b); end
    endtask

    task automatic test_collision();
        logic [47:0] exp;
        logic [67:0] texp;
        int acc_at = -1;
        in_ready = 1'b1;
        @(negedge clk);
        con_valid = 1'b1; hd1 = 16'h0011; hd2 = 16'h0022; hd3 = 16'h0033;
        res_valid = 1'b1; res_data = 48'h5555_6666_7777; res_x = 7'd1; res_y = 7'd2; res_ch = 6'd3;
        #1;
        checks++; if (con_ready !== 1'b0) begin failures++; $display("FAIL coll_no_accept got=%b exp=0", con_ready); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (output_valid) begin
                checks++;
                if (tx_q.size() == 0) begin failures++; $display("FAIL coll_tx_extra got=%h exp=none", {con_3, con_2, con_1}); end
                else begin texp = tx_q.pop_front(); if ({con_3, con_2, con_1, output_x, output_y, output_ch} !== texp) begin failures++; $display("FAIL coll_tx_data got=%h exp=%h", {con_3, con_2, con_1, output_x, output_y, output_ch}, texp); end end
            end
            if (in_valid) begin
                checks++;
                if (rx_q.size() == 0) begin failures++; $display("FAIL coll_rx_extra got=%h exp=none", in_data); end
                else begin exp = rx_q.pop_front(); if (in_data !== exp) begin failures++; $display("FAIL coll_rx_data got=%h exp=%h", in_data, exp); end end
            end
            res_valid = (c <= 1);
            con_valid = (acc_at < 0);
            #1;
            if (c == 4) begin
                checks++; if (con_ready !== 1'b0) begin failures++; $display("FAIL coll_turn_rx_ready got=%b exp=0", con_ready); end
            end
            if (res_valid && res_ready) tx_q.push_back({res_data, res_x, res_y, res_ch});
            if (con_valid && con_ready) begin acc_at = c; rx_q.push_back({hd3, hd2, hd1}); end
        end
        checks++; if (acc_at != 5) begin failures++; $display("FAIL coll_accept_cycle got=%0d exp=5", acc_at); end
        checks++; if (rx_q.size() != 0 || tx_q.size() != 0) begin failures++; $display("FAIL coll_queues got=%0d/%0d exp=0/0", rx_q.size(), tx_q.size()); end
        con_valid = 1'b0;
    endtask

    task automatic test_reset_mid_tx();
        hd1 = 16'h0; hd2 = 16'h0; hd3 = 16'h0;
        @(negedge clk);
        res_valid = 1'b1; res_data = 48'hFFFF_EEEE_DDDD; res_x = 7'd9; res_y = 7'd8; res_ch = 6'd7;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (output_valid !== 1'b1 || dut_driving_cons !== 1'b1) begin failures++; $display("FAIL midtx_active got=%b/%b exp=1/1", output_valid, dut_driving_cons); end
        arst_n = 1'b0;
        #1;
        checks++; if (dut_driving_cons !== 1'b0 || output_valid !== 1'b0) begin failures++; $display("FAIL midtx_release got=%b/%b exp=0/0", dut_driving_cons, output_valid); end
        checks++; if ({con_3, con_2, con_1} !== 48'h0 || res_ready !== 1'b0) begin failures++; $display("FAIL midtx_lanes got=%h/%b exp=0/0", {con_3, con_2, con_1}, res_ready); end
        checks++; if ({output_x, output_y, output_ch} !== 20'h0) begin failures++; $display("FAIL midtx_coords got=%h exp=0", {output_x, output_y, output_ch}); end
        res_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        checks++; if (con_ready !== 1'b1 || dut_driving_cons !== 1'b0 || in_valid !== 1'b0) begin failures++; $display("FAIL midtx_after got=%b/%b/%b exp=1/0/0", con_ready, dut_driving_cons, in_valid); end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_fifo_full();
        test_kernel();
        test_back_to_back_tx();
        test_collision();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
